// File: rtl/decodificacao_pipeline_pkg.sv
// Shared encodings for the decode pipeline: opcodes, format codes, buffer states
// and the decoded-field record held in each buffer entry.
package decod_pkg;

  typedef enum logic [2:0] {
    TIPO_R      = 3'b000,
    TIPO_I      = 3'b001,
    TIPO_S      = 3'b010,
    TIPO_B      = 3'b011,
    TIPO_U      = 3'b100,
    TIPO_J      = 3'b101,
    TIPO_ILEGAL = 3'b111
  } tipo_t;

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    CHEIO = 2'd2
  } estado_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    tipo_t      tipo;
    logic       ilegal;
  } campos_t;

endpackage

// File: rtl/decodificacao_pipeline_if.sv
// Upstream/downstream handshake plus decoded outputs of the decode pipeline.
interface decodificacao_pipeline_if
  import decod_pkg::*;
#(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instrucao;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] immediate;
  logic            negativo;
  tipo_t           tipo;
  logic            ilegal;

  modport slave (
    input  in_valid, instrucao, out_ready,
    output in_ready, out_valid, opcode, rd, rs1, rs2, funct3, funct7,
           immediate, negativo, tipo, ilegal
  );

  modport master (
    output in_valid, instrucao, out_ready,
    input  in_ready, out_valid, opcode, rd, rs1, rs2, funct3, funct7,
           immediate, negativo, tipo, ilegal
  );
endinterface

// File: rtl/decodificacao_pipeline_gerador_imediato.sv
// Combinational format classifier and sign-extended immediate builder.
module gerador_imediato
  import decod_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit ENABLE_UJ = 1'b1
) (
  input  logic [31:0]     instrucao,
  output tipo_t           tipo,
  output logic [XLEN-1:0] immediate,
  output logic            ilegal
);
  logic [31:0] imm32;

  always_comb begin
    tipo  = TIPO_ILEGAL;
    imm32 = '0;
    if (instrucao[1:0] == 2'b11) begin
      case (instrucao[6:0])
        OP_R: tipo = TIPO_R;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
          tipo  = TIPO_I;
          imm32 = {{20{instrucao[31]}}, instrucao[31:20]};
        end
        OP_STORE: begin
          tipo  = TIPO_S;
          imm32 = {{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
        end
        OP_BRANCH: begin
          tipo  = TIPO_B;
          imm32 = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                   instrucao[30:25], instrucao[11:8], 1'b0};
        end
        OP_LUI, OP_AUIPC: begin
          if (ENABLE_UJ) begin
            tipo  = TIPO_U;
            imm32 = {instrucao[31:12], 12'b0};
          end
        end
        OP_JAL: begin
          if (ENABLE_UJ) begin
            tipo  = TIPO_J;
            imm32 = {{11{instrucao[31]}}, instrucao[31], instrucao[19:12],
                     instrucao[20], instrucao[30:21], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign ilegal    = (tipo == TIPO_ILEGAL);
  assign immediate = XLEN'($signed(imm32));
endmodule

// File: rtl/decodificacao_pipeline.sv
// Instruction decoder behind a two-entry skid buffer; entries hold decoded
// fields so the output side is a straight register read.
module decodificacao_pipeline
  import decod_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit ENABLE_UJ = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  flush,
  decodificacao_pipeline_if.slave bus
);
  tipo_t           tipo_dec;
  logic            ilegal_dec;
  logic [XLEN-1:0] imm_dec;
  campos_t         dec;

  estado_t         estado;
  logic            in_ready_q;
  logic            out_valid_q;
  campos_t         head;
  campos_t         skid;
  logic [XLEN-1:0] head_imm;
  logic [XLEN-1:0] skid_imm;
  logic            aceita;
  logic            entrega;

  gerador_imediato #(.XLEN(XLEN), .ENABLE_UJ(ENABLE_UJ)) u_gerador (
    .instrucao (bus.instrucao),
    .tipo      (tipo_dec),
    .immediate (imm_dec),
    .ilegal    (ilegal_dec)
  );

  // Fields a format does not carry are forced to zero; opcode is always raw.
  always_comb begin
    dec        = '0;
    dec.opcode = bus.instrucao[6:0];
    dec.tipo   = tipo_dec;
    dec.ilegal = ilegal_dec;
    if (tipo_dec inside {TIPO_R, TIPO_I, TIPO_U, TIPO_J})
      dec.rd = bus.instrucao[11:7];
    if (tipo_dec inside {TIPO_R, TIPO_I, TIPO_S, TIPO_B}) begin
      dec.rs1    = bus.instrucao[19:15];
      dec.funct3 = bus.instrucao[14:12];
    end
    if (tipo_dec inside {TIPO_R, TIPO_S, TIPO_B})
      dec.rs2 = bus.instrucao[24:20];
    if (tipo_dec == TIPO_R)
      dec.funct7 = bus.instrucao[31:25];
  end

  assign aceita  = bus.in_valid & in_ready_q;
  assign entrega = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= VAZIO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head        <= '0;
      head_imm    <= '0;
      skid        <= '0;
      skid_imm    <= '0;
    end else if (flush) begin
      estado      <= VAZIO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (estado)
        VAZIO: begin
          if (aceita) begin
            head        <= dec;
            head_imm    <= imm_dec;
            out_valid_q <= 1'b1;
            estado      <= UM;
          end
        end
        UM: begin
          if (aceita && !entrega) begin
            skid       <= dec;
            skid_imm   <= imm_dec;
            in_ready_q <= 1'b0;
            estado     <= CHEIO;
          end else if (aceita && entrega) begin
            head     <= dec;
            head_imm <= imm_dec;
          end else if (entrega) begin
            out_valid_q <= 1'b0;
            estado      <= VAZIO;
          end
        end
        CHEIO: begin
          if (entrega) begin
            head       <= skid;
            head_imm   <= skid_imm;
            in_ready_q <= 1'b1;
            estado     <= UM;
          end
        end
        default: begin
          estado      <= VAZIO;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.opcode    = head.opcode;
  assign bus.rd        = head.rd;
  assign bus.rs1       = head.rs1;
  assign bus.rs2       = head.rs2;
  assign bus.funct3    = head.funct3;
  assign bus.funct7    = head.funct7;
  assign bus.tipo      = head.tipo;
  assign bus.ilegal    = head.ilegal;
  assign bus.immediate = head_imm;
  assign bus.negativo  = head_imm[XLEN-1];
endmodule

// File: doc/decodificacao_pipeline.md
DECODIFICACAO_PIPELINE -- requirements
Module: decodificacao_pipeline

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter ENABLE_UJ, default 1; when 1, U/J formats decode, when 0, U/J opcodes are illegal.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all buffered instructions.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, instrucao input 32: upstream handshake and instruction word.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-008 SHALL have outputs opcode 7, rd 5, rs1 5, rs2 5, funct3 3, funct7 7: instruction fields.
REQ-009 SHALL have outputs immediate XLEN (sign-extended), negativo 1 (immediate MSB), tipo 3 (format), ilegal 1 (undecodable word).

Function
REQ-010 SHALL accept a word when in_valid&&in_ready, and deliver it when out_valid&&out_ready.
REQ-011 SHALL register outputs; accepted word appears on outputs no earlier than the next cycle (latency 1 into an empty block).
REQ-012 SHALL hold a 2-entry skid buffer with states VAZIO (0 entries), UM (1), CHEIO (2); in_ready = (state != CHEIO), registered.
REQ-013 SHALL transition: VAZIO+accept->UM; UM+accept-only->CHEIO; UM+deliver-only->VAZIO; UM+accept+deliver->UM; CHEIO+deliver->UM; otherwise hold.
REQ-014 SHALL keep all outputs stable while out_valid=1 and out_ready=0.
REQ-015 SHALL deliver in strict acceptance order; no word lost or duplicated.
REQ-016 SHALL decode tipo: 000 R (0110011); 001 I (0010011, 0000011, 1100111, 1110011); 010 S (0100011); 011 B (1100011); 100 U (0110111, 0010111); 101 J (1101111); 111 illegal.
REQ-017 SHALL set ilegal=1, tipo=111, immediate=0, negativo=0 when instrucao[1:0]!=11, the opcode is unlisted, or it is U/J with ENABLE_UJ=0.
REQ-018 SHALL build immediates sign-extended from instrucao[31] to XLEN: I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0}; U {31:12,12'b0}; J {31,19:12,20,30:21,0}; R yields 0.
REQ-019 SHALL drive fields unused by the decoded format (rd for S/B, rs1/rs2 for U/J, rs2 for I, funct7 outside R, funct3 for U/J) to 0.
REQ-020 SHALL make flush take priority over in_valid in the same cycle: no word accepted; state VAZIO, out_valid=0 next cycle.
REQ-021 SHALL treat out_ready as don't-care while out_valid=0.

Reset
REQ-022 SHALL, on reset high at a clock edge, enter VAZIO: out_valid=0, in_ready=1, all field outputs, immediate, negativo, ilegal 0, tipo 000.
REQ-023 SHALL abort in-flight words on mid-operation reset; reset has priority over flush and handshakes.

Structure
REQ-024 SHALL take opcode constants, tipo encodings and state encodings from a shared package (decod_pkg).
REQ-025 SHALL use one combinational sub-module, gerador_imediato (instrucao, XLEN -> tipo, immediate, ilegal), instantiated once at the buffer input.
REQ-026 SHALL store decoded results, not raw words, in the buffer entries.

Verification
REQ-027 SHALL check 0xFFB10093 (addi x1,x2,-5), out_ready=1 -> next cycle tipo=001, rd=1, rs1=2, funct3=0, immediate=0xFFFFFFFB, negativo=1.
REQ-028 SHALL check 0x00512423 (sw x5,8(x2)) -> tipo=010, rs1=2, rs2=5, funct3=010, immediate=8, rd=0; and 0xFE208EE3 (beq x1,x2,-4) -> tipo=011, immediate=0xFFFFFFFC.
REQ-029 SHALL check out_ready=0 with three back-to-back words -> in_ready=0 after second accept; third held upstream; release yields all three in order.
REQ-030 SHALL check 0x00000000 -> ilegal=1, tipo=111, immediate=0; with ENABLE_UJ=0, 0x0000006F -> ilegal=1.
REQ-031 SHALL check flush in CHEIO with in_valid=1 -> next cycle out_valid=0, in_ready=1, word not accepted; reset mid-stream behaves likewise.
REQ-032 SHALL check XLEN=64 with 0x800000B7 (lui x1,0x80000) -> tipo=100, rd=1, immediate=0xFFFFFFFF80000000.
